// File: rtl/key_stream_tx.sv
// key_stream_tx: keyboard transmit side. ASCII bytes come in over a
// valid/ready handshake, sit in a small FIFO, and are replayed as one-hot
// pulses on a 128-line key bus (bit index = ASCII code). An ETX byte ends
// the stream: it is held on the bus with Done=1 until Restart.
module key_stream_tx #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [7:0]               InData,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic                     Stall,
    input  logic                     Restart,
    output logic [127:0]             Keys,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Done,
    output logic [7:0]               DropCnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [6:0] ETX = 7'h03;

    typedef enum logic [1:0] {IDLE, HOLD, GAP, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [127:0]    keys_nx;
    logic [6:0]      mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            etx_seen;
    logic            full, empty;
    logic            push, store, drop;
    logic            pop, flush, launch;
    logic [6:0]      head;

    // Extra wrap bit distinguishes full from empty when the indexes match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Ready ignores a same-cycle pop so the handshake never depends on the FSM.
    assign InReady = Rst && !full && !etx_seen;
    assign push    = InValid && InReady;
    assign store   = push && !InData[7];
    assign drop    = push && InData[7];

    assign Level = wr_ptr - rd_ptr;
    assign Done  = (state == DONE);

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge Clk) begin
        if (store) mem[wr_ptr[AW-1:0]] <= InData[6:0];
    end

    // Next-state logic. A new pulse may launch from IDLE or directly at the
    // end of a HOLD/GAP, so back-to-back bytes have no idle cycle between.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        keys_nx  = Keys;
        pop      = 1'b0;
        flush    = 1'b0;
        launch   = 1'b0;
        case (state)
            IDLE: launch = 1'b1;
            HOLD: begin
                if (cnt == '0) begin
                    keys_nx = '0;
                    if (GAP_CYCLES > 0) begin
                        state_nx = GAP;
                        cnt_nx   = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
                    end else begin
                        state_nx = IDLE;
                        launch   = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    launch   = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                if (Restart) begin
                    state_nx = IDLE;
                    keys_nx  = '0;
                    flush    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (launch && !empty && !Stall) begin
            pop           = 1'b1;
            keys_nx       = '0;
            keys_nx[head] = 1'b1;
            if (head == ETX) begin
                state_nx = DONE;
            end else begin
                state_nx = HOLD;
                cnt_nx   = CW'(HOLD_CYCLES - 1);
            end
        end
    end

    // State, key bus, FIFO pointers, ETX latch and drop counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            Keys     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            etx_seen <= 1'b0;
            DropCnt  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            Keys  <= keys_nx;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                etx_seen <= 1'b0;
            end else begin
                if (store) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
                if (store && InData[6:0] == ETX) etx_seen <= 1'b1;
            end
            if (drop && DropCnt != 8'hFF) DropCnt <= DropCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_key_stream_tx.sv
// Directed bench for key_stream_tx: a vector table for the single-cycle
// handshake/pulse behaviour plus hand-written multi-cycle sequences.
module tb_key_stream_tx;

    logic         Clk, Rst;
    logic [7:0]   InData;
    logic         InValid, InReady, Stall, Restart;
    logic [127:0] Keys;
    logic [4:0]   Level;
    logic         Done;
    logic [7:0]   DropCnt;

    // Second instance with inter-pulse gap
    logic [7:0]   g_data;
    logic         g_valid, g_ready, g_stall, g_restart, g_done;
    logic [127:0] g_keys;
    logic [4:0]   g_level;
    logic [7:0]   g_drop;

    int n_checks = 0;
    int n_fail   = 0;

    key_stream_tx #(.DEPTH(16), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady),
        .Stall(Stall), .Restart(Restart), .Keys(Keys), .Level(Level), .Done(Done),
        .DropCnt(DropCnt)
    );

    key_stream_tx #(.DEPTH(16), .HOLD_CYCLES(1), .GAP_CYCLES(2)) dut_g (
        .Clk(Clk), .Rst(Rst), .InData(g_data), .InValid(g_valid), .InReady(g_ready),
        .Stall(g_stall), .Restart(g_restart), .Keys(g_keys), .Level(g_level), .Done(g_done),
        .DropCnt(g_drop)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       st;
        logic       rs;
        logic       rdy;   // InReady before the edge
        int         key;   // key bit after the edge, -1 = all zero
        int         lvl;
        logic       dn;
        int         drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic st, logic rs,
                                logic rdy, int key, int lvl, logic dn, int drop);
        vec_t r;
        r.v = v; r.d = d; r.st = st; r.rs = rs; r.rdy = rdy;
        r.key = key; r.lvl = lvl; r.dn = dn; r.drop = drop;
        return r;
    endfunction

    function automatic logic [127:0] kv(int k);
        logic [127:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int   acc_at;
        logic pre;
        int   gexp[6];

        Rst = 1'b0; InValid = 1'b0; InData = '0; Stall = 1'b0; Restart = 1'b0;
        g_valid = 1'b0; g_data = '0; g_stall = 1'b0; g_restart = 1'b0;

        //        v  data   st rs  rdy key  lvl dn drop
        // "lab" back to back; Restart outside DONE is ignored
        tbl.push_back(mk(1, 8'h6C, 0, 0, 1,  -1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h61, 0, 0, 1, 108, 1, 0, 0));
        tbl.push_back(mk(1, 8'h62, 0, 1, 1,  97, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  98, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  -1, 0, 0, 0));
        // non-ASCII bytes mixed with a valid one
        tbl.push_back(mk(1, 8'h80, 0, 0, 1,  -1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h5A, 0, 0, 1,  -1, 1, 0, 1));
        tbl.push_back(mk(1, 8'hFF, 0, 0, 1,  90, 0, 0, 2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  -1, 0, 0, 2));
        // 'A', ETX, then 'B' refused; Restart with InValid in DONE
        tbl.push_back(mk(1, 8'h41, 0, 0, 1,  -1, 1, 0, 2));
        tbl.push_back(mk(1, 8'h03, 0, 0, 1,  65, 1, 0, 2));
        tbl.push_back(mk(1, 8'h42, 0, 0, 0,   3, 0, 1, 2));
        tbl.push_back(mk(1, 8'h42, 0, 0, 0,   3, 0, 1, 2));
        tbl.push_back(mk(1, 8'h42, 0, 1, 0,  -1, 0, 0, 2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  -1, 0, 0, 2));

        // Reset state
        #12;
        chk("rst_keys", Keys, '0);
        chk("rst_level", Level, '0);
        chk("rst_ready", InReady, 0);
        chk("rst_done", Done, 0);
        chk("rst_drop", DropCnt, '0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        #1 chk("ready_after_rst", InReady, 1);

        // Table
        foreach (tbl[i]) begin
            InValid = tbl[i].v; InData = tbl[i].d; Stall = tbl[i].st; Restart = tbl[i].rs;
            #1;
            chk($sformatf("v%0d_ready", i), InReady, tbl[i].rdy);
            tick();
            chk($sformatf("v%0d_keys", i), Keys, kv(tbl[i].key));
            chk($sformatf("v%0d_level", i), Level, 128'(tbl[i].lvl));
            chk($sformatf("v%0d_done", i), Done, tbl[i].dn);
            chk($sformatf("v%0d_drop", i), DropCnt, 128'(tbl[i].drop));
        end
        InValid = 1'b0; Restart = 1'b0; Stall = 1'b0;

        // Gap instance: 0x20 then 0x0A with two zero cycles between pulses
        gexp = '{-1, 32, -1, -1, 10, -1};
        for (int k = 0; k < 6; k++) begin
            g_valid = (k < 2);
            g_data  = (k == 0) ? 8'h20 : 8'h0A;
            tick();
            chk($sformatf("gap_%0d", k), g_keys, kv(gexp[k]));
        end
        g_valid = 1'b0;
        chk("gap_level", g_level, '0);

        // Fill under Stall, then release
        Stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            InValid = 1'b1; InData = 8'h30 + 8'(i);
            tick();
        end
        InData = 8'h40;
        #1;
        chk("full_ready", InReady, 0);
        chk("full_level", Level, 128'd16);
        tick();
        tick();
        chk("stall_keys", Keys, '0);
        chk("stall_level", Level, 128'd16);
        Stall = 1'b0;
        acc_at = -1;
        for (int k = 0; k < 17; k++) begin
            pre = InReady;
            tick();
            if (InValid && pre) begin
                InValid = 1'b0;
                acc_at  = k;
            end
            chk($sformatf("drain_%0d", k), Keys, kv(8'h30 + k));
        end
        chk("byte17_accept_cycle", 128'(acc_at), 128'd1);
        InValid = 1'b0;
        tick();
        chk("drain_end_keys", Keys, '0);
        chk("drain_end_level", Level, '0);

        // Drop counter saturation
        InValid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            InData = 8'h80 | 8'(i % 128);
            tick();
        end
        InValid = 1'b0;
        chk("drop_sat", DropCnt, 128'd255);
        chk("drop_level", Level, '0);
        chk("drop_keys", Keys, '0);

        // Reset in the middle of a pulse
        InValid = 1'b1; InData = 8'h73;
        tick();
        InData = 8'h74;
        tick();
        InValid = 1'b0;
        chk("mid_keys", Keys, kv(115));
        chk("mid_level", Level, 128'd1);
        Rst = 1'b0;
        #1;
        chk("mid_rst_keys", Keys, '0);
        chk("mid_rst_level", Level, '0);
        chk("mid_rst_ready", InReady, 0);
        chk("mid_rst_drop", DropCnt, '0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        InValid = 1'b1; InData = 8'h72;
        tick();
        InValid = 1'b0;
        chk("post_rst_k0", Keys, '0);
        tick();
        chk("post_rst_k1", Keys, kv(114));
        tick();
        chk("post_rst_k2", Keys, '0);
        chk("post_rst_level", Level, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_stream_tx.md
Name: key_stream_tx

Overview:
- Transmit side of the MiniComputer keyboard interface.
- Takes ASCII bytes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each byte as a one-hot key pulse on the 128-line key bus, bit index = ASCII code (bit0 = null … bit127 = del).
- Terminates a program with a held ETX, so whole assembly sources can be streamed into the on-chip assembler without hand-driven key lines.

Parameters:
DEPTH, 16, FIFO depth in bytes (power of two, ≥2)
HOLD_CYCLES, 1, cycles each key line stays high (≥1)
GAP_CYCLES, 0, all-zero cycles inserted after each key pulse (≥0)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous reset, active-low
InData  input  8  ASCII byte from host
InValid  input  1  InData valid
InReady  output  1  byte accepted when InValid && InReady at rising Clk
Stall  input  1  receiver busy; no new key pulse may start while high
Restart  input  1  synchronous one-cycle pulse; leaves DONE, clears Keys
Keys  output  128  one-hot key bus {del,…,null}
Level  output  $clog2(DEPTH)+1  FIFO occupancy
Done  output  1  ETX has been emitted and is being held
DropCnt  output  8  count of dropped non-ASCII bytes, saturating at 255

Behaviour:
- Reset (Rst low, asynchronous):
  - Keys=0, Level=0, Done=0, DropCnt=0, InReady=0 while asserted.
  - FIFO pointers cleared, state=IDLE, EtxSeen=0.
  - After release: InReady=1 from the first cycle.
- InReady = !full && !EtxSeen, registered-free combinational. A pop in the same cycle does not make a full FIFO ready.
- Push rules:
  - Byte with InData[7]=1 is accepted (handshake completes), not stored, and DropCnt increments.
  - Byte 0x03 (ETX) is stored and sets EtxSeen. No further bytes are accepted until Restart or reset.
- Simultaneous push and pop: Level unchanged; both the data and the pointers update correctly.
- Pointer wrap: modulo DEPTH with an extra wrap bit for full/empty.
- States:
  - IDLE: Keys=0. If FIFO not empty and Stall=0, pop the head, load Keys with the one-hot of that byte on the next edge, go to HOLD with cnt=HOLD_CYCLES-1. If the popped byte is 0x03, go to DONE instead.
  - HOLD: Keys held. cnt=0 → Keys=0 and go to GAP (cnt=GAP_CYCLES-1) if GAP_CYCLES>0, else go to IDLE. Otherwise cnt decrements.
  - GAP: Keys=0. cnt=0 → go to IDLE, else cnt decrements.
  - DONE: Keys=32'h… bit3 only (etx) held indefinitely, Done=1. Restart → Keys=0, Done=0, EtxSeen=0, FIFO flushed, go to IDLE.
- Back-to-back timing with GAP_CYCLES=0: bytes in the FIFO produce consecutive one-cycle pulses on distinct bits with no zero cycle between them. A repeated identical byte therefore appears as a multi-cycle high on one bit; the host inserts the separation it needs.
- Latency: a byte pushed at edge N into an empty FIFO in IDLE with Stall=0 appears on Keys after edge N+1.
- Stall:
  - Sampled only in IDLE.
  - A pulse already in HOLD or GAP completes regardless of Stall.
  - Stall held high in IDLE keeps Keys=0 and the FIFO intact.
- Restart:
  - Outside DONE, ignored.
  - Simultaneous with InValid in DONE: the byte is not accepted (InReady=0 that cycle).
- Keys is always one-hot or zero; never two bits set.
- Reset mid-pulse: Keys drops to 0 immediately (asynchronous), and the FIFO contents are lost.

Test Plan:
- Reset, then push "lab" (0x6C,0x61,0x62) on consecutive cycles → Keys = bit108, bit97, bit98 on three consecutive cycles starting one cycle after the first push, then 0; Level returns to 0.
- Push 17 bytes with DEPTH=16, Stall=1 → InReady low after 16 accepts; Level=16. Release Stall → 16 pulses in order, then the 17th byte is accepted once InReady rises.
- GAP_CYCLES=2, HOLD_CYCLES=1: push 0x20,0x0A → Keys bit32 for 1 cycle, 0 for 2 cycles, bit10 for 1 cycle.
- Push 0x41, 0x03, then 0x42 → bit65 pulse, then bit3 held with Done=1; 0x42 never accepted (InReady=0). Restart → Keys=0, Done=0, InReady=1.
- Push 0x80 and 0xFF among valid bytes → both consumed without pulses; DropCnt=2. Push 300 invalid bytes → DropCnt=255.
- Assert Rst low during a HOLD of 0x73 (bit115) → Keys=0 immediately, Level=0; after release the next push of 0x72 produces bit114 only.
